// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU between the EX stage (requester 0) and the
// branch/compare unit (requester 1). Round-robin grant, registered ALU inputs,
// registered responses. Fixed 2-cycle accept-to-response latency.
// Optional macro ALU_SHARE_OPCHECK_EN adds per-requester illegal-opcode flags.
module alu_share_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             req0Valid,
    output logic             req0Ready,
    input  logic [3:0]       req0Op,
    input  logic [WIDTH-1:0] req0A,
    input  logic [WIDTH-1:0] req0B,
    input  logic             req1Valid,
    output logic             req1Ready,
    input  logic [3:0]       req1Op,
    input  logic [WIDTH-1:0] req1A,
    input  logic [WIDTH-1:0] req1B,
    output logic             rsp0Valid,
    output logic [WIDTH-1:0] rsp0Result,
    output logic             rsp0Zero,
    output logic             rsp1Valid,
    output logic [WIDTH-1:0] rsp1Result,
    output logic             rsp1Zero,
    output logic [3:0]       aluControlOp,
    output logic [WIDTH-1:0] aluNumberA,
    output logic [WIDTH-1:0] aluNumberB,
    input  logic [WIDTH-1:0] aluResult,
    input  logic             aluIsZero
`ifdef ALU_SHARE_OPCHECK_EN
    ,
    output logic             rsp0Illegal,
    output logic             rsp1Illegal
`endif
);

    logic issue_valid;
    logic issue_tag;
    logic last_grant;
    logic grant0_c;
    logic grant1_c;
    logic accept_c;

    // Round-robin grant: a lone requester always wins, a conflict goes to the one not served last.
    always_comb begin
        grant0_c = req0Valid && (!req1Valid || last_grant);
        grant1_c = req1Valid && (!req0Valid || !last_grant);
        accept_c = grant0_c || grant1_c;
    end

    assign req0Ready = grant0_c;
    assign req1Ready = grant1_c;

    // Stage 1: latch the winner into the ALU input registers; hold them when idle.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            issue_valid  <= 1'b0;
            issue_tag    <= 1'b0;
            last_grant   <= 1'b1;
            aluControlOp <= 4'b0;
            aluNumberA   <= '0;
            aluNumberB   <= '0;
        end else begin
            issue_valid <= accept_c;
            if (accept_c) begin
                issue_tag    <= grant1_c;
                last_grant   <= grant1_c;
                aluControlOp <= grant1_c ? req1Op : req0Op;
                aluNumberA   <= grant1_c ? req1A  : req0A;
                aluNumberB   <= grant1_c ? req1B  : req0B;
            end
        end
    end

    // Stage 2: capture the ALU result into the issuing requester's response registers.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            rsp0Valid  <= 1'b0;
            rsp0Result <= '0;
            rsp0Zero   <= 1'b0;
            rsp1Valid  <= 1'b0;
            rsp1Result <= '0;
            rsp1Zero   <= 1'b0;
        end else begin
            rsp0Valid <= issue_valid && !issue_tag;
            rsp1Valid <= issue_valid && issue_tag;
            if (issue_valid && !issue_tag) begin
                rsp0Result <= aluResult;
                rsp0Zero   <= aluIsZero;
            end
            if (issue_valid && issue_tag) begin
                rsp1Result <= aluResult;
                rsp1Zero   <= aluIsZero;
            end
        end
    end

`ifdef ALU_SHARE_OPCHECK_EN
    logic issue_illegal;
    logic op_illegal_c;

    // Opcode legality of the operation being accepted this cycle.
    always_comb begin
        op_illegal_c = 1'b1;
        case (grant1_c ? req1Op : req0Op)
            4'b0000, 4'b0001, 4'b0010,
            4'b0110, 4'b0111, 4'b1100: op_illegal_c = 1'b0;
            default:                   op_illegal_c = 1'b1;
        endcase
    end

    // Carry the illegal flag alongside the issued op so it pulses with the response.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            issue_illegal <= 1'b0;
            rsp0Illegal   <= 1'b0;
            rsp1Illegal   <= 1'b0;
        end else begin
            if (accept_c) begin
                issue_illegal <= op_illegal_c;
            end
            rsp0Illegal <= issue_valid && !issue_tag && issue_illegal;
            rsp1Illegal <= issue_valid && issue_tag && issue_illegal;
        end
    end
`endif

endmodule
